lsu_bus_if: RTL

- Load/store unit directly downstream of the core datapath.
- Consumes the ALU result as the effective address, the store-data operand, and the control strobes.
- Drives a single-outstanding request/acknowledge memory bus.
- Returns sign- or zero-extended load data to the datapath result mux; stalls the pipeline until the access completes.
- Detects misaligned accesses, illegal funct3 encodings and bus timeouts, and reports each as a one-cycle fault.

---
 rtl/lsu_bus_if_if.sv | 31 +++
 rtl/lsu_bus_if.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_if_if.sv
// Memory-side bus of the load/store unit: single-outstanding request with
// a one-cycle acknowledge pulse returning read data.
interface lsu_bus_if_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/lsu_bus_if.sv
// Load/store unit: turns datapath load/store strobes into one bus access,
// stalls the pipeline until it completes, and flags misalignment/illegal/timeout.
module lsu_bus_if #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [2:0]   funct3,
    input  logic [31:0]  addr,
    input  logic [31:0]  wdata,
    output logic [31:0]  rdata,
    output logic         stall,
    output logic         fault,
    lsu_bus_if_if.master bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wd_q, wd_d;
    logic [1:0]         off_q, off_d;
    logic [2:0]         f3_q, f3_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               fault_q, fault_d;

    logic               acc_req;
    logic               acc_write;
    logic               f3_ok;
    logic               aligned;
    logic               acc_legal;
    logic [3:0]         be_new;
    logic [31:0]        wd_new;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_ext;

    // Request decode: legality, lane enables and replicated store data.
    always_comb begin
        acc_req   = mem_read | mem_write;
        acc_write = mem_write;
        aligned   = 1'b1;
        be_new    = 4'hF;
        wd_new    = wdata;
        if (acc_write) begin
            f3_ok = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
        end else begin
            f3_ok = !((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));
        end
        unique case (funct3[1:0])
            2'b00: begin
                aligned = 1'b1;
                be_new  = 4'b0001 << addr[1:0];
                wd_new  = {4{wdata[7:0]}};
            end
            2'b01: begin
                aligned = ~addr[0];
                be_new  = addr[1] ? 4'b1100 : 4'b0011;
                wd_new  = {2{wdata[15:0]}};
            end
            default: begin
                aligned = (addr[1:0] == 2'b00);
                be_new  = 4'hF;
                wd_new  = wdata;
            end
        endcase
        acc_legal = f3_ok & aligned;
    end

    // Load lane select uses the offset and size captured at request time.
    always_comb begin
        ld_byte = bus.bus_rdata[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        unique case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h000000, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0000, ld_half};
            default: ld_ext = bus.bus_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        off_d   = off_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (acc_req) begin
                    if (acc_legal) begin
                        req_d   = 1'b1;
                        we_d    = acc_write;
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = be_new;
                        wd_d    = wd_new;
                        off_d   = addr[1:0];
                        f3_d    = funct3;
                        cnt_d   = '0;
                        state_d = ST_BUS;
                    end else begin
                        fault_d = 1'b1;
                        rdata_d = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BUS: begin
                // An ack on the last allowed cycle takes priority over the timeout.
                if (bus.bus_ack) begin
                    req_d   = 1'b0;
                    rdata_d = we_q ? '0 : ld_ext;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    rdata_d = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign stall         = ~reset & (((state_q == ST_IDLE) & acc_req) | (state_q == ST_BUS));
    assign rdata         = rdata_q;
    assign fault         = fault_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wd_q;

endmodule
